// File: rtl/aes_inv_mix_columns.sv
// ============================================================================
// aes_inv_mix_columns
// Iterative AES InvMixColumns: one shared column datapath, four cycles/state.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_inv_mix_columns (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] c_reduce = 8'h1b;

  state_t        r_fsm;
  logic [1:0]    r_col;
  logic [127:0]  r_state;
  logic [31:0]   w_col_in;
  logic [31:0]   w_col_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? c_reduce : 8'h00);
  endfunction

  // 9/b/d/e multiples share the x2, x4, x8 chain of each input byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a   [4];
    logic [7:0] x2  [4];
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m9  [4];
    logic [7:0] mb  [4];
    logic [7:0] md  [4];
    logic [7:0] me  [4];
    a[0] = col[31:24];
    a[1] = col[23:16];
    a[2] = col[15:8];
    a[3] = col[7:0];
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_comb begin
    w_col_in = r_state[127:96];
    case (r_col)
      2'd0: w_col_in = r_state[127:96];
      2'd1: w_col_in = r_state[95:64];
      2'd2: w_col_in = r_state[63:32];
      2'd3: w_col_in = r_state[31:0];
      default: w_col_in = r_state[127:96];
    endcase
  end

  assign w_col_out = inv_mix_col(w_col_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= ST_IDLE;
      r_col   <= 2'd0;
      r_state <= '0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= in_state;
            r_col   <= 2'd0;
            r_fsm   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          case (r_col)
            2'd0: r_state[127:96] <= w_col_out;
            2'd1: r_state[95:64]  <= w_col_out;
            2'd2: r_state[63:32]  <= w_col_out;
            2'd3: r_state[31:0]   <= w_col_out;
            default: r_state[127:96] <= w_col_out;
          endcase
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_fsm <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_fsm <= ST_IDLE;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  // Partially transformed state is never exposed outside DONE.
  assign in_ready  = (r_fsm == ST_IDLE);
  assign out_valid = (r_fsm == ST_DONE);
  assign out_state = (r_fsm == ST_DONE) ? r_state : '0;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_mix_columns.sv
// ============================================================================
// tb_aes_inv_mix_columns
// Self-checking bench: GF(2^8) matrix reference model plus per-cycle compare.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes_inv_mix_columns;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  localparam logic [127:0] c_fips_in  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] c_fips_out = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] c_ones     = 128'h01010101_01010101_01010101_01010101;
  localparam logic [127:0] c_red_in   = 128'h8e4da1bc_8e4da1bc_8e4da1bc_8e4da1bc;
  localparam logic [127:0] c_red_out  = 128'hdb135345_db135345_db135345_db135345;

  aes_inv_mix_columns dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: generic shift-and-add GF(2^8) multiply, matrix-vector product.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_imc(input logic [127:0] s);
    logic [7:0]   coef [4][4];
    logic [127:0] r;
    logic [7:0]   acc;
    coef[0] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    coef[1] = '{8'h09, 8'h0e, 8'h0b, 8'h0d};
    coef[2] = '{8'h0d, 8'h09, 8'h0e, 8'h0b};
    coef[3] = '{8'h0b, 8'h0d, 8'h09, 8'h0e};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(s[(127 - 32*c - 8*k) -: 8], coef[row][k]);
        r[(127 - 32*c - 8*row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural timing model: phase 0 = idle, 1..4 = busy cycles, 5 = result held.
  int           m_phase  = 0;
  logic [127:0] m_result = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  = 0;
      m_result = '0;
    end else begin
      if (m_phase == 0) begin
        if (in_valid) begin
          m_result = ref_imc(in_state);
          m_phase  = 1;
        end
      end else if (m_phase < 5) begin
        m_phase = m_phase + 1;
      end else if (out_ready) begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_out_state", out_state, 128'd0);
    end else begin
      chk("in_ready", {127'd0, in_ready}, {127'd0, m_phase == 0});
      chk("out_valid", {127'd0, out_valid}, {127'd0, m_phase == 5});
      if (m_phase == 5) chk("out_state", out_state, m_result);
    end
  end

  int lat;

  task automatic wait_out(output int n);
    n = 0;
    while (n < 12) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) break;
    end
  endtask

  // Entered and left at posedge+2 with the unit idle and out_ready=1.
  task automatic xfer(input string nm, input logic [127:0] v, input logic [127:0] exp);
    in_state = v;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    wait_out(lat);
    chk({nm, "_latency"}, 128'(lat), 128'd4);
    chk({nm, "_result"}, out_state, exp);
    @(posedge clk); #1;
    chk({nm, "_valid_drop"}, {127'd0, out_valid}, 128'd0);
    chk({nm, "_ready_back"}, {127'd0, in_ready}, 128'd1);
    #1;
  endtask

  logic [127:0] v;
  logic [127:0] v2;
  logic [127:0] held;
  logic [127:0] vecs [5];
  int           acc_cyc [4];
  int           n;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_state  = c_fips_in;
    out_ready = 1'b1;

    chk("model_fips", ref_imc(c_fips_in), c_fips_out);
    chk("model_ones", ref_imc(c_ones), c_ones);
    chk("model_reduce", ref_imc(c_red_in), c_red_out);

    repeat (3) @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #2;

    xfer("fips", c_fips_in, c_fips_out);
    xfer("zero", 128'd0, 128'd0);
    xfer("ones", c_ones, c_ones);
    xfer("reduce", c_red_in, c_red_out);

    for (int i = 0; i < 20; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      xfer("random", v, ref_imc(v));
    end

    // Backpressure with in_valid held high throughout DONE.
    v  = {$urandom, $urandom, $urandom, $urandom};
    v2 = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    in_state  = v;
    in_valid  = 1'b1;
    @(posedge clk); #2;
    in_state = v2;
    wait_out(lat);
    chk("bp_result", out_state, ref_imc(v));
    held = out_state;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_state", out_state, held);
      chk("bp_hold_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_hold_ready", {127'd0, in_ready}, 128'd0);
    end
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", {127'd0, out_valid}, 128'd0);
    chk("bp_idle", {127'd0, in_ready}, 128'd1);
    #1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_next_latency", 128'(lat), 128'd4);
    chk("bp_next_result", out_state, ref_imc(v2));
    @(posedge clk); #2;

    // Reset two cycles into BUSY.
    in_state = c_fips_in;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_out_state", out_state, 128'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    v = {$urandom, $urandom, $urandom, $urandom};
    xfer("after_rst", v, ref_imc(v));

    // Back-to-back accepts with in_valid always high.
    vecs[0] = c_fips_in;
    vecs[1] = c_red_in;
    vecs[2] = c_ones;
    vecs[3] = {$urandom, $urandom, $urandom, $urandom};
    vecs[4] = '0;
    in_state = vecs[0];
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!in_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      @(posedge clk); #1;
      acc_cyc[i] = cyc;
      in_state = vecs[i+1];
      if (i == 3) in_valid = 1'b0;
      if (i > 0) chk("b2b_spacing", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd6);
      wait_out(lat);
      chk("b2b_latency", 128'(lat), 128'd4);
      chk("b2b_result", out_state, ref_imc(vecs[i]));
    end
    chk("b2b_first_literal", ref_imc(vecs[0]), c_fips_out);
    repeat (3) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
